seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, parametrised-width integer ALU with a valid/ready handshake on both sides. It keeps the existing 4-bit operation encoding (ADD..DIV) and adds REM and SRA. It replaces the combinational multiplier/divider with iterative shift-add and restoring-division engines. It sits between the decode/issue stage and writeback in the CPU datapath and stalls issue through `in_ready` while a long operation runs.

## Interface
- `WIDTH`, default 32: operand/result width; legal range 8..64.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands/opcode valid.
- `in_ready` output 1: block can accept an operation.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `alu_control` input 4: operation code.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: operation result.
- `zero` output 1: `result == 0`, valid while `out_valid`.
- `div_by_zero` output 1: DIV/REM was issued with `b == 0`, valid while `out_valid`.
- `busy` output 1: state is not IDLE.
- Reset is asynchronous and active-high.
- `reset` drives all state and outputs to their reset values immediately, independent of `clk`.

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SRL, 0110 SLT, 0111 MUL, 1000 DIV, 1001 REM, 1010 SRA, others → result 0.
- ADD, SUB, MUL: modulo 2^WIDTH. MUL returns the low WIDTH bits of the unsigned product.
- SLT: unsigned compare; returns 1 or 0.
- Shifts use `b[$clog2(WIDTH)-1:0]`. SRA replicates `a[WIDTH-1]`.
- DIV and REM are unsigned. Quotient truncates.
- DIV with `b == 0`: quotient all-ones, `div_by_zero = 1`.
- REM with `b == 0`: result `a`, `div_by_zero = 1`.
- `div_by_zero` is 0 for every other case.
- Operands and opcode are captured at acceptance. Later changes on the inputs have no effect.
- State machine:
  - **IDLE**: `in_ready = 1`. On `in_valid`:
    - MUL → MUL state.
    - DIV or REM → DIV state, unless `b == 0`, which goes straight to DONE.
    - All other opcodes → DONE with the result computed.
  - **MUL**: one shift-add step per cycle, WIDTH steps, then DONE.
  - **DIV**: one restoring step per cycle, WIDTH steps, then DONE. The final remainder serves REM.
  - **DONE**: `out_valid = 1`; `result`, `zero` and `div_by_zero` are held stable. On `out_ready` → IDLE.
- `in_ready` is low in MUL, DIV and DONE. An operation arriving while `in_ready = 0` is not accepted and stays pending upstream.
- Reset values: state IDLE, `in_ready = 1` (as a function of state), `out_valid = 0`, `result = 0`, `zero = 0`, `div_by_zero = 0`, `busy = 0`, iteration counter 0.
- Reset mid-operation abandons the operation. No result is produced.

## Timing
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs, except that `in_ready` depends on state only.
- Single-cycle ops: accepted at edge N → `out_valid` after edge N+1.
- MUL, DIV and REM: accepted at edge N → `out_valid` after edge N+WIDTH+1.
- DIV/REM with `b == 0`: latency 1.
- Result leaves at the edge where `out_valid && out_ready`. `in_ready` rises the following cycle.
- Throughput: at best one operation every 2 cycles.
- `out_ready` held low: DONE persists indefinitely with outputs unchanged.

## Configuration
- `SEQ_ALU_FAST_MUL_EN` defined: MUL is computed with a single-cycle `*` and goes IDLE → DONE with latency 1. The MUL state and shift-add engine are not built.
- `SEQ_ALU_FAST_MUL_EN` undefined: iterative MUL with latency WIDTH+1.
- DIV and REM are iterative in both configurations.

## Test plan
- Reset mid-DIV: issue DIV, assert `reset` at cycle 5 → immediately `busy = 0`, `out_valid = 0`, `result = 0`. The next ADD 2+3 returns 5 at latency 1.
- WIDTH=32, ADD 0xFFFFFFFF+1 → `result = 0`, `zero = 1`, `out_valid` one cycle after acceptance. SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0x10000 × 0x10001 → 0x00010000. Latency 33 without the macro, 1 with `SEQ_ALU_FAST_MUL_EN`. `in_ready = 0` throughout.
- DIV 100/7 → 14. REM 100/7 → 2. Both latency 33, `div_by_zero = 0`.
- DIV 5/0 → 0xFFFFFFFF with `div_by_zero = 1`. REM 5/0 → 5 with `div_by_zero = 1`. Both latency 1.
- Backpressure: hold `out_ready = 0` for 10 cycles after SUB 3−5 → `result = 0xFFFFFFFE` stable, `in_ready = 0`. Raise `out_ready` → `in_ready = 1` the next cycle.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU with valid/ready handshakes, shift-add multiplier and restoring divider.
// Optional feature macro: SEQ_ALU_FAST_MUL_EN selects a single-cycle '*' multiplier instead of the iterative engine.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_SLL = 4'h4, OP_SRL = 4'h5, OP_SLT = 4'h6, OP_MUL = 4'h7,
    OP_DIV = 4'h8, OP_REM = 4'h9, OP_SRA = 4'hA
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifndef SEQ_ALU_FAST_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] work_a;   // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] work_b;   // multiplier, or divisor
  logic [WIDTH-1:0] acc;      // partial product, or partial remainder
  logic            is_rem;

  op_e              op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_comb;

  assign op       = op_e'(alu_control);
  assign shamt    = b[SHW-1:0];
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // NOTE: every signal driven in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    alu_comb = '0;
    case (op)
      OP_ADD: alu_comb = a + b;
      OP_SUB: alu_comb = a - b;
      OP_AND: alu_comb = a & b;
      OP_OR:  alu_comb = a | b;
      OP_SLL: alu_comb = a << shamt;
      OP_SRL: alu_comb = a >> shamt;
      OP_SLT: alu_comb = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA: alu_comb = $unsigned($signed(a) >>> shamt);
`ifdef SEQ_ALU_FAST_MUL_EN
      OP_MUL: alu_comb = a * b;
`endif
      // Only reached for a zero divisor; non-zero divisors take the iterative path.
      OP_DIV: alu_comb = '1;
      OP_REM: alu_comb = a;
      default: alu_comb = '0;
    endcase
  end

  // One restoring-division step: shift the next dividend bit into the remainder and try subtracting.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] div_final;

  always_comb begin
    rem_shift = {acc, work_a[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, work_b};
    if (!rem_diff[WIDTH]) begin
      rem_next = rem_diff[WIDTH-1:0];
      quo_next = {work_a[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {work_a[WIDTH-2:0], 1'b0};
    end
    div_final = is_rem ? rem_next : quo_next;
  end

`ifndef SEQ_ALU_FAST_MUL_EN
  logic [WIDTH-1:0] mul_sum;
  assign mul_sum = acc + (work_b[0] ? work_a : '0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      work_a      <= '0;
      work_b      <= '0;
      acc         <= '0;
      is_rem      <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            case (op)
`ifndef SEQ_ALU_FAST_MUL_EN
              OP_MUL: begin
                work_a <= a;
                work_b <= b;
                acc    <= '0;
                cnt    <= CW'(WIDTH - 1);
                state  <= S_MUL;
              end
`endif
              OP_DIV, OP_REM: begin
                if (b == '0) begin
                  result      <= alu_comb;
                  zero        <= (alu_comb == '0);
                  div_by_zero <= 1'b1;
                  state       <= S_DONE;
                end else begin
                  work_a <= a;
                  work_b <= b;
                  acc    <= '0;
                  is_rem <= (op == OP_REM);
                  cnt    <= CW'(WIDTH - 1);
                  state  <= S_DIV;
                end
              end
              default: begin
                result      <= alu_comb;
                zero        <= (alu_comb == '0);
                div_by_zero <= 1'b0;
                state       <= S_DONE;
              end
            endcase
          end
        end
`ifndef SEQ_ALU_FAST_MUL_EN
        S_MUL: begin
          acc    <= mul_sum;
          work_a <= work_a << 1;
          work_b <= work_b >> 1;
          if (cnt == '0) begin
            result      <= mul_sum;
            zero        <= (mul_sum == '0);
            div_by_zero <= 1'b0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        S_DIV: begin
          acc    <= rem_next;
          work_a <= quo_next;
          if (cnt == '0) begin
            result      <= div_final;
            zero        <= (div_final == '0);
            div_by_zero <= 1'b0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): a driver pushes expected responses, a monitor pops and compares.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  alu_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        div_by_zero;
  logic        busy;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef SEQ_ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zr;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the first cycle of each out_valid pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && !seen) begin
      exp_t e;
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_result_count", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, 64'(result), 64'(e.res));
        check({e.name, "_zero"}, 64'(zero), 64'(e.zr));
        check({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        check({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
    if (!out_valid) seen = 1'b0;
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] er, input logic ed, input int el);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({name, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    a           = ia;
    b           = ib;
    alu_control = op;
    @(posedge clk);
    #1;
    e.name = name; e.res = er; e.zr = (er == 32'd0); e.dbz = ed; e.lat = el; e.acc = cyc;
    exp_q.push_back(e);
    // Scramble inputs after acceptance: the captured operation must not change.
    in_valid    = 1'b0;
    a           = $urandom;
    b           = $urandom;
    alu_control = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    issue("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    issue("sra",      4'hA, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1);
    issue("and",      4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
    issue("or",       4'h3, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1'b0, 1);
    issue("sll_31",   4'h4, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1);
    issue("sll_mask", 4'h4, 32'h1, 32'd36, 32'h10, 1'b0, 1);
    issue("srl",      4'h5, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1);
    issue("slt_lt",   4'h6, 32'd3, 32'd5, 32'd1, 1'b0, 1);
    issue("slt_uns",  4'h6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    issue("bad_op",   4'hF, 32'd7, 32'd9, 32'd0, 1'b0, 1);

    issue("mul", 4'h7, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, MUL_LAT);
    ok = 1'b1;
    while (exp_q.size() != 0 && !out_valid) begin
      if (in_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("mul_in_ready_low", 64'(ok), 64'd1);
    issue("mul_ones", 4'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, MUL_LAT);

    issue("div",      4'h8, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    issue("rem",      4'h9, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    issue("div_max",  4'h8, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
    issue("rem_max",  4'h9, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 33);
    issue("div_zero", 4'h8, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    issue("rem_zero", 4'h9, 32'd5, 32'd0, 32'd5, 1'b1, 1);
    drain();

    // Backpressure: result held while out_ready stays low.
    out_ready = 1'b0;
    issue("sub_bp", 4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (result !== 32'hFFFF_FFFE || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_stable", 64'(ok), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    drain();

    // Reset mid-division abandons the operation.
    issue("div_abort", 4'h8, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    issue("add_after_rst", 4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
